// File: rtl/lit_selector_bp_if.sv
// lit_selector_bp_if: literal/copy request and history-bank write bundle for lit_selector_bp
//   sources (master drives): lit_valid, data_lit, lit_address, byte_valid_in, copy_valid, data_copy,
//   address_copy, byte_valid_copy, out_ready; selector (slave drives): rd_out, copy_ready,
//   data_out, address_out, byte_valid_out, valid_out
interface lit_selector_bp_if #(
  parameter int NUM_PARSER = 6,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
);
  logic [NUM_PARSER-1:0] lit_valid;
  logic [DATA_W*NUM_PARSER-1:0] data_lit;
  logic [ADDR_W*NUM_PARSER-1:0] lit_address;
  logic [(DATA_W/8)*NUM_PARSER-1:0] byte_valid_in;
  logic [NUM_PARSER-1:0] rd_out;
  logic copy_valid;
  logic [DATA_W-1:0] data_copy;
  logic [ADDR_W-1:0] address_copy;
  logic [DATA_W/8-1:0] byte_valid_copy;
  logic copy_ready;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] address_out;
  logic [DATA_W/8-1:0] byte_valid_out;
  logic valid_out;
  logic out_ready;
  modport master (
    output lit_valid, data_lit, lit_address, byte_valid_in, copy_valid, data_copy, address_copy,
           byte_valid_copy, out_ready,
    input rd_out, copy_ready, data_out, address_out, byte_valid_out, valid_out
  );
  modport slave (
    input lit_valid, data_lit, lit_address, byte_valid_in, copy_valid, data_copy, address_copy,
          byte_valid_copy, out_ready,
    output rd_out, copy_ready, data_out, address_out, byte_valid_out, valid_out
  );
endinterface

// File: rtl/lit_selector_bp.sv
// lit_selector_bp: picks one literal or copy write per cycle into a 2-entry buffered history-bank port
//   ports: clk, rst (sync, active-high), bus (lit_selector_bp_if.slave: literal/copy requests in,
//   rd_out/copy_ready pops out, buffered data_out/address_out/byte_valid_out/valid_out with out_ready)
module lit_selector_bp #(
  parameter int NUM_PARSER = 6,
  parameter int NUM_LOG = 3,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9,
  parameter logic [NUM_PARSER-1:0] BASE_INIT = 1,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  lit_selector_bp_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int W = DATA_W + ADDR_W + BE_W;
  localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [1:0] cnt, keep;
  logic [NUM_PARSER-1:0] base, grant;
  logic [2*NUM_PARSER-1:0] dreq, dgnt;
  logic [SW-1:0] starve_cnt;
  logic [NUM_LOG-1:0] idx;
  logic [W-1:0] ent0, ent1, w;
  logic any_lit, accept, starve, copy_win, lit_win, push, pop;
  assign any_lit = |bus.lit_valid;
  assign accept = ~rst & (cnt < 2'd2);
  assign starve = (STARVE_MAX != 0) & (starve_cnt >= SMAX) & any_lit;
  assign copy_win = accept & bus.copy_valid & ~starve;
  assign lit_win = accept & ~copy_win & any_lit;
  assign push = copy_win | lit_win;
  assign pop = bus.valid_out & bus.out_ready;
  // doubled request vector: subtracting base isolates the first requester at/above base, with wrap
  assign dreq = {bus.lit_valid, bus.lit_valid};
  assign dgnt = dreq & ~(dreq - {{NUM_PARSER{1'b0}}, base});
  assign grant = dgnt[NUM_PARSER-1:0] | dgnt[2*NUM_PARSER-1:NUM_PARSER];
  assign bus.rd_out = lit_win ? grant : '0;
  assign bus.copy_ready = copy_win;
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_PARSER; i++) idx = grant[i] ? NUM_LOG'(i) : idx;
  end
  assign w = copy_win ? {bus.data_copy, bus.address_copy, bus.byte_valid_copy}
                      : {bus.data_lit[idx*DATA_W +: DATA_W], bus.lit_address[idx*ADDR_W +: ADDR_W],
                         bus.byte_valid_in[idx*BE_W +: BE_W]};
  // occupancy once this cycle's pop is taken; the push lands in that slot
  assign keep = cnt - {1'b0, pop};
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      base <= BASE_INIT;
      starve_cnt <= '0;
    end else begin
      cnt <= keep + {1'b0, push};
      if (lit_win) base <= {grant[NUM_PARSER-2:0], grant[NUM_PARSER-1]};
      if (lit_win || (accept && !any_lit)) starve_cnt <= '0;
      else if (copy_win && starve_cnt < SMAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (pop) ent0 <= ent1;
    if (push && keep == 2'd0) ent0 <= w;
    else if (push) ent1 <= w;
  end
  assign bus.valid_out = cnt != 2'd0;
  assign {bus.data_out, bus.address_out, bus.byte_valid_out} = ent0;
endmodule

// File: doc/lit_selector_bp.md
Name: lit_selector_bp

Overview:
- Parametrised successor of the literal/copy write selector in the decompressor datapath.
- Picks one write per cycle from NUM_PARSER literal sources and one copy-result source, and feeds a single history-RAM bank.
- New over the previous generation:
  - generic data/address widths;
  - downstream backpressure through a 2-entry output buffer;
  - copy-path backpressure;
  - an anti-starvation guard so literals cannot be blocked indefinitely by copy traffic;
  - a round-robin pointer that holds on idle and copy cycles.

Parameters:
- NUM_PARSER, 6, number of literal sources (>=2).
- NUM_LOG, 3, ceil(log2(NUM_PARSER)).
- DATA_W, 64, write data width in bits (multiple of 8).
- ADDR_W, 9, bank address width.
- BASE_INIT, 1, one-hot initial round-robin pointer (NUM_PARSER bits).
- STARVE_MAX, 4, consecutive copy wins allowed while a literal waits; 0 disables the guard.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- lit_valid  in  NUM_PARSER  per-source literal request.
- data_lit  in  DATA_W*NUM_PARSER  literal data; source i occupies slice i.
- lit_address  in  ADDR_W*NUM_PARSER  literal addresses.
- byte_valid_in  in  (DATA_W/8)*NUM_PARSER  literal byte enables.
- rd_out  out  NUM_PARSER  one-hot pop to the granted literal source; combinational.
- copy_valid  in  1  copy-result request.
- data_copy  in  DATA_W  copy data.
- address_copy  in  ADDR_W  copy address.
- byte_valid_copy  in  DATA_W/8  copy byte enables.
- copy_ready  out  1  copy accepted this cycle; combinational.
- data_out  out  DATA_W  head-of-buffer data.
- address_out  out  ADDR_W  head address.
- byte_valid_out  out  DATA_W/8  head byte enables.
- valid_out  out  1  buffer non-empty.
- out_ready  in  1  downstream consumes the head when valid_out=1.

Behaviour:
- **Accept gating:** accept = (cnt<2), where cnt is the output buffer occupancy (0..2). When accept=0: rd_out=0, copy_ready=0, no state changes except the pop.
- **Starvation flag:** starve = (STARVE_MAX!=0) & (starve_cnt>=STARVE_MAX) & (lit_valid!=0).
- **Selection, when accept=1:**
  - copy_valid & ~starve: copy wins. copy_ready=1, rd_out=0.
  - Otherwise, if lit_valid!=0: a literal wins. grant = round-robin over lit_valid starting at one-hot base (first requester at or above base, wrapping). rd_out=grant, copy_ready=0.
  - Otherwise: no write.
- **Data path:** the winner's data, address and byte enables are pushed into the buffer at the clock edge.
- **Latency:** 1 cycle from acceptance to valid_out when the buffer is empty. FIFO order is preserved.
- **Output buffer:**
  - pop = valid_out & out_ready.
  - Push and pop in the same cycle leaves cnt unchanged.
  - Outputs are driven from buffer registers only (no combinational path from inputs to data_out).
  - data_out, address_out and byte_valid_out are don't-care while valid_out=0.
- **Round-robin base:**
  - On a literal win: base <= grant rotated left by 1, with bit NUM_PARSER-1 wrapping to bit 0.
  - On a copy win, an idle cycle, or accept=0: base holds.
- **starve_cnt** (width ceil(log2(STARVE_MAX+1)), saturating at STARVE_MAX):
  - Increment on a copy win while lit_valid!=0.
  - Clear on a literal win.
  - Clear when lit_valid==0.
  - Otherwise hold.
- **Reset (synchronous, rst=1), state:**
  - cnt=0, base=BASE_INIT, starve_cnt=0.
  - Buffer contents are undefined.
- **Reset, outputs:**
  - valid_out=0.
  - rd_out=0 and copy_ready=0 during reset, regardless of inputs.
  - Reset mid-burst discards buffered entries; no pop or grant is issued in the reset cycle.
- **Source obligations:**
  - A source holds its request, data, address and byte enables stable until popped.
  - A request may be withdrawn only while it is not being granted.

Test Plan:
- **Reset:** rst=1 for 2 cycles with all requests high → valid_out=0, rd_out=0, copy_ready=0. First cycle after release, lit_valid=6'b000001 → rd_out=000001; valid_out=1 the next cycle carrying source 0's data.
- **Round-robin fairness:** lit_valid=6'b111111 held, out_ready=1 → rd_out sequence 000001, 000010, 000100, 001000, 010000, 100000, 000001; exactly one write per cycle.
- **Copy priority and starvation guard:** STARVE_MAX=4, copy_valid=1 and lit_valid=6'b000100 held → four copy wins, then rd_out=000100 with copy_ready=0 in cycle 5, then copy wins again. With STARVE_MAX=0, copy wins every cycle.
- **Backpressure:** out_ready=0, lit_valid=6'b000011 → two grants (000001, 000010), then rd_out=0 with cnt=2. Raise out_ready → outputs appear in order src0, src1, and a grant resumes in the cycle after the first pop.
- **Base hold:** literal win on source 2, then 3 copy-only cycles, then lit_valid=6'b111111 → next grant is source 3.
- **Mid-operation reset:** cnt=2, rst pulsed for 1 cycle → valid_out=0 the next cycle; base back to 000001; starve_cnt=0 (verified by four further copy wins before a forced literal).
